// File: rtl/uno_pkg.sv
// rtl/uno_pkg.sv - shared card encoding, deck constants and canonical deck order
package uno_pkg;

    typedef logic [5:0] card_t;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        BLUE   = 2'd3
    } colour_t;

    localparam logic [3:0] SKIP      = 4'd10;
    localparam logic [3:0] REVERSE   = 4'd11;
    localparam logic [3:0] DRAW_TWO  = 4'd12;
    localparam logic [3:0] WILD      = 4'd13;
    localparam logic [3:0] WILD_FOUR = 4'd14;

    localparam card_t CARD_EMPTY = 6'h3F;
    localparam int    DECK_SIZE  = 108;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHUFFLE,
        ST_READY,
        ST_EMPTY
    } state_t;

    // Card held by a deck slot before shuffling: 25 cards per colour
    // (one 0, then 1..12 twice), followed by four wilds and four wild draw-fours.
    function automatic card_t canon_card(input logic [6:0] slot);
        colour_t    colour;
        logic [6:0] rank;
        logic [3:0] value;
        if (slot >= 7'd104) begin
            return {2'b00, WILD_FOUR};
        end
        if (slot >= 7'd100) begin
            return {2'b00, WILD};
        end
        if (slot >= 7'd75) begin
            colour = BLUE;
            rank   = slot - 7'd75;
        end else if (slot >= 7'd50) begin
            colour = GREEN;
            rank   = slot - 7'd50;
        end else if (slot >= 7'd25) begin
            colour = YELLOW;
            rank   = slot - 7'd25;
        end else begin
            colour = RED;
            rank   = slot;
        end
        value = (rank == 7'd0) ? 4'd0 : 4'((rank + 7'd1) >> 1);
        return {colour, value};
    endfunction

    // True for cards that carry an action rather than a plain number.
    function automatic logic is_action_card(input card_t card);
        return (card[3:0] == SKIP) || (card[3:0] == REVERSE) || (card[3:0] == DRAW_TWO) ||
               (card[3:0] == WILD) || (card[3:0] == WILD_FOUR);
    endfunction

endpackage

// File: rtl/uno_lfsr.sv
// rtl/uno_lfsr.sv - right-shifting Galois LFSR with synchronous load
module uno_lfsr #(
    parameter int           W         = 16,
    parameter logic [W-1:0] MASK      = 16'hB400,
    parameter logic [W-1:0] RESET_VAL = 16'hACE1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    input  logic         i_advance,
    output logic [W-1:0] o_q
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // One Galois step: shift right, fold the mask in when a 1 falls out
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ MASK;
        end
    end

    // Load wins over advance so a restart always begins from the new seed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= RESET_VAL;
        end else if (i_load) begin
            lfsr_q <= i_seed;
        end else if (i_advance) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_q = lfsr_q;

endmodule

// File: rtl/uno_deck_dealer.sv
// rtl/uno_deck_dealer.sv - UNO deck owner: fill, Fisher-Yates shuffle, deal (option UNO_DECK_RESHUFFLE_EN)
module uno_deck_dealer
    import uno_pkg::*;
#(
    parameter int                DECK_SIZE    = uno_pkg::DECK_SIZE,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_draw,
    output logic              o_drawn,
    output logic [5:0]        o_card,
    output logic              o_busy,
    output logic              o_empty,
    output logic [6:0]        o_remaining
);

    localparam logic [6:0] LAST_SLOT  = 7'(DECK_SIZE - 1);
    localparam logic [6:0] FULL_COUNT = 7'(DECK_SIZE);

    state_t     state_q;
    logic [6:0] slot_q;
    logic       phase_q;
    logic [6:0] ptr_q;
    logic [6:0] remaining_q;
    logic       pending_q;
    logic       busy_q;
    logic       empty_q;
    logic       drawn_q;
    card_t      card_q;

    card_t      deck_q [DECK_SIZE];
    card_t      hold_i_q;
    card_t      hold_j_q;
    logic [6:0] swap_j_q;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] load_seed;
    logic              lfsr_advance;
    logic [6:0]        swap_j;
    logic              unused_lfsr_low;

    assign load_seed    = (i_seed == '0) ? DEFAULT_SEED : i_seed;
    assign lfsr_advance = (state_q == ST_SHUFFLE) && phase_q && !i_start;

    uno_lfsr #(
        .W         (LFSR_W),
        .MASK      (16'hB400),
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (i_start),
        .i_seed    (load_seed),
        .i_advance (lfsr_advance),
        .o_q       (lfsr_q)
    );

    // Scaled random index: (i+1) * r / 128 with a 7-bit r always lands in 0..i
    assign swap_j = 7'((({7'd0, slot_q} + 14'd1) * {7'd0, lfsr_q[LFSR_W-1 -: 7]}) >> 7);
    assign unused_lfsr_low = ^lfsr_q[LFSR_W-8:0];

    // Deck storage: canonical fill during INIT, read-both-then-swap during SHUFFLE
    always_ff @(posedge i_clk) begin
        if (state_q == ST_INIT) begin
            deck_q[slot_q] <= canon_card(slot_q);
        end else if (state_q == ST_SHUFFLE) begin
            if (!phase_q) begin
                hold_i_q <= deck_q[slot_q];
                hold_j_q <= deck_q[swap_j];
                swap_j_q <= swap_j;
            end else begin
                deck_q[slot_q]   <= hold_j_q;
                deck_q[swap_j_q] <= hold_i_q;
            end
        end
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            phase_q     <= 1'b0;
            ptr_q       <= '0;
            remaining_q <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            empty_q     <= 1'b1;
            drawn_q     <= 1'b0;
            card_q      <= CARD_EMPTY;
        end else begin
            drawn_q <= 1'b0;
            if (i_start) begin
                // A draw arriving with the restart is remembered, not lost
                state_q     <= ST_INIT;
                slot_q      <= '0;
                phase_q     <= 1'b0;
                ptr_q       <= '0;
                remaining_q <= '0;
                busy_q      <= 1'b1;
                empty_q     <= 1'b1;
                pending_q   <= pending_q | i_draw;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                    end
                    ST_INIT: begin
                        if (i_draw) begin
                            pending_q <= 1'b1;
                        end
                        if (slot_q == LAST_SLOT) begin
                            state_q <= ST_SHUFFLE;
                            phase_q <= 1'b0;
                        end else begin
                            slot_q <= slot_q + 7'd1;
                        end
                    end
                    ST_SHUFFLE: begin
                        if (i_draw) begin
                            pending_q <= 1'b1;
                        end
                        phase_q <= ~phase_q;
                        if (phase_q) begin
                            if (slot_q == 7'd1) begin
                                state_q     <= ST_READY;
                                busy_q      <= 1'b0;
                                empty_q     <= 1'b0;
                                ptr_q       <= '0;
                                remaining_q <= FULL_COUNT;
                            end else begin
                                slot_q <= slot_q - 7'd1;
                            end
                        end
                    end
                    ST_READY: begin
                        if (i_draw || pending_q) begin
                            // Serving the held draw keeps a simultaneous new one pending
                            drawn_q     <= 1'b1;
                            card_q      <= deck_q[ptr_q];
                            ptr_q       <= ptr_q + 7'd1;
                            remaining_q <= remaining_q - 7'd1;
                            pending_q   <= pending_q & i_draw;
                            if (ptr_q == LAST_SLOT) begin
                                empty_q <= 1'b1;
                                state_q <= ST_EMPTY;
                            end
                        end
                    end
                    ST_EMPTY: begin
`ifdef UNO_DECK_RESHUFFLE_EN
                        // Rebuild the deck on demand; the LFSR carries on unseeded
                        if (i_draw || pending_q) begin
                            pending_q <= 1'b1;
                            state_q   <= ST_INIT;
                            slot_q    <= '0;
                            phase_q   <= 1'b0;
                            ptr_q     <= '0;
                            busy_q    <= 1'b1;
                        end
`else
                        // Answer with the empty marker so a requester never waits forever
                        if (i_draw || pending_q) begin
                            drawn_q   <= 1'b1;
                            card_q    <= CARD_EMPTY;
                            pending_q <= 1'b0;
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_drawn     = drawn_q;
    assign o_card      = card_q;
    assign o_busy      = busy_q;
    assign o_empty     = empty_q;
    assign o_remaining = remaining_q;

endmodule
